// File: rtl/gcd_scheduler_if.sv
// Bundle of requester, GCD-core and response signals for gcd_scheduler.
// The master view belongs to the scheduler and the slave view to its environment.
interface gcd_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       gnt;
  logic                   gcd_start;
  logic [WIDTH-1:0]       gcd_data_in;
  logic                   gcd_done;
  logic [WIDTH-1:0]       gcd_result;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_gcd;
  logic                   rsp_err;
  logic                   busy;

  modport master (
    input  req, req_a, req_b, gcd_done, gcd_result, rsp_ready,
    output gnt, gcd_start, gcd_data_in, rsp_valid, rsp_id, rsp_gcd, rsp_err, busy
  );

  modport slave (
    output req, req_a, req_b, gcd_done, gcd_result, rsp_ready,
    input  gnt, gcd_start, gcd_data_in, rsp_valid, rsp_id, rsp_gcd, rsp_err, busy
  );
endinterface

// File: rtl/gcd_scheduler.sv
// Round-robin scheduler sharing one subtractive GCD core among N_REQ requesters,
// with a zero-operand shortcut and a per-job RUN timeout.
module gcd_scheduler #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 65600
) (
  input  logic            clk,
  input  logic            rst,
  gcd_scheduler_if.master bus
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, RUN, RESP} state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  last, winner, scan, win_id;
  logic             found, timed_out;
  logic [WIDTH-1:0] a_arr [N_REQ];
  logic [WIDTH-1:0] b_arr [N_REQ];
  logic [WIDTH-1:0] win_a, win_b, op_a, op_b, rsp_gcd_q;
  logic             rsp_err_q;
  logic [N_REQ-1:0] gnt_q;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      a_arr[i] = bus.req_a[i*WIDTH +: WIDTH];
      b_arr[i] = bus.req_b[i*WIDTH +: WIDTH];
    end
  end

  // Scan from last+1 upwards so the most recent winner has lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = last;
    scan   = last;
    for (int k = 1; k <= N_REQ; k++) begin
      scan = ID_W'((int'(last) + k) % N_REQ);
      if (!found && bus.req[scan]) begin
        found  = 1'b1;
        winner = scan;
      end
    end
  end

  assign win_a     = a_arr[winner];
  assign win_b     = b_arr[winner];
  assign timed_out = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_nxt       = state;
    bus.gcd_start   = 1'b0;
    bus.gcd_data_in = '0;
    bus.rsp_valid   = 1'b0;
    bus.busy        = (state != IDLE);
    case (state)
      IDLE: begin
        // The core never terminates on a zero operand, so answer A|B directly.
        if (found) state_nxt = (win_a == '0 || win_b == '0) ? RESP : LOAD_A;
      end
      LOAD_A: begin
        bus.gcd_start   = 1'b1;
        bus.gcd_data_in = op_a;
        state_nxt       = LOAD_B;
      end
      LOAD_B: begin
        bus.gcd_start   = 1'b1;
        bus.gcd_data_in = op_b;
        state_nxt       = RUN;
      end
      RUN: begin
        bus.gcd_data_in = op_b;
        if (bus.gcd_done || timed_out) state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last      <= ID_W'(N_REQ - 1);
      win_id    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_gcd_q <= '0;
      rsp_err_q <= 1'b0;
      gnt_q     <= '0;
      cnt       <= '0;
    end else begin
      gnt_q <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            last      <= winner;
            win_id    <= winner;
            op_a      <= win_a;
            op_b      <= win_b;
            gnt_q     <= N_REQ'(1) << winner;
            rsp_gcd_q <= win_a | win_b;
            rsp_err_q <= 1'b0;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (bus.gcd_done) begin
            rsp_gcd_q <= bus.gcd_result;
            rsp_err_q <= 1'b0;
          end else if (timed_out) begin
            rsp_gcd_q <= '0;
            rsp_err_q <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.rsp_id  = win_id;
  assign bus.rsp_gcd = rsp_gcd_q;
  assign bus.rsp_err = rsp_err_q;
endmodule

// File: doc/gcd_scheduler.md
# gcd_scheduler

- Shares one GCD datapath/controlpath pair among `N_REQ` requesters.
- Arbitrates round-robin and latches the winner's operand pair.
- Sequences the pair onto the core's single `data_in` bus (A, then B) with `start`, then waits for `done` and returns the result tagged with the requester index.
- Shortcuts zero operands, which the subtractive core cannot terminate on, and bounds every job with a timeout.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 16, operand/result width
- `TIMEOUT`, 65600, maximum RUN cycles before a job is aborted
- `clk`  in  1  clock; everything is sampled on the rising edge
- `rst`  in  1  synchronous reset, active-high
- `req`  in  N_REQ  level request, one bit per requester
- `req_a`  in  N_REQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH]
- `req_b`  in  N_REQ*WIDTH  operand B; same packing as `req_a`
- `gnt`  out  N_REQ  one-hot, one-cycle pulse when a request is accepted
- `gcd_start`  out  1  start to the GCD controlpath
- `gcd_data_in`  out  WIDTH  operand bus to the GCD datapath
- `gcd_done`  in  1  done from the GCD controlpath
- `gcd_result`  in  WIDTH  result from the GCD datapath (A register)
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  response consumer ready
- `rsp_id`  out  clog2(N_REQ)  index of the requester being answered
- `rsp_gcd`  out  WIDTH  GCD result
- `rsp_err`  out  1  job aborted by timeout
- `busy`  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, LOAD_A, LOAD_B, RUN, RESP.
- IDLE:
  - If any `req` bit is set, choose the winner round-robin, starting at `last+1` modulo N_REQ.
  - Latch winner index, A and B; update `last`.
- IDLE exit:
  - If either latched operand is 0, go to RESP with result = A|B: (0,x)->x, (x,0)->x, (0,0)->0. The core is not touched.
  - Otherwise go to LOAD_A.
- `gnt[winner]` is high for exactly the first cycle after the arbitration edge (LOAD_A, or RESP in the zero case).
- Requester contract:
  - Hold `req` and operands stable until its `gnt` pulse.
  - `req` still high after `gnt` counts as a new request.
- LOAD_A: `gcd_start`=1, `gcd_data_in`=A. Always go to LOAD_B.
- LOAD_B: `gcd_start`=1, `gcd_data_in`=B. Always go to RUN.
- RUN:
  - `gcd_start`=0, `gcd_data_in` holds B.
  - The timeout counter increments each cycle.
  - `gcd_done`=1: latch `gcd_result`, set `rsp_err`=0, go to RESP.
  - Counter reaches TIMEOUT with no done: set `rsp_gcd`=0, `rsp_err`=1, go to RESP.
  - `gcd_done` is ignored in every other state. The core clears done when it sees `gcd_start`.
- RESP:
  - `rsp_valid`=1; `rsp_id`/`rsp_gcd`/`rsp_err` stay stable until `rsp_valid && rsp_ready` at an edge.
  - After the handshake, go to IDLE and clear the counter.
  - No arbitration occurs while `busy`.
- Reset at any time, including mid-RUN or mid-RESP:
  - Next state is IDLE; the in-flight job is dropped with no response.
  - `last` = N_REQ-1, so requester 0 has first priority.
- Reset value of every output: `gnt`=0, `gcd_start`=0, `gcd_data_in`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_gcd`=0, `rsp_err`=0, `busy`=0.
- All outputs are registered or decoded directly from state and registers. There is no combinational path from `req` or `gcd_done` to any output.

## Timing
- Arbitration edge E0 (IDLE, `req`≠0):
  - Cycle 1: `gnt` and LOAD_A.
  - Cycle 2: LOAD_B.
  - Cycle 3 onward: RUN.
- `gcd_done` sampled high at edge Ed: `rsp_valid` is high in the cycle after Ed.
- Zero shortcut: `rsp_valid` is high in cycle 1, together with `gnt`.
- Timeout: `rsp_valid` rises in the cycle after the TIMEOUT-th RUN cycle.
- Back-to-back jobs: handshake edge, then one IDLE cycle, then the next arbitration edge. Minimum job spacing is 5 cycles through the core and 2 cycles via the shortcut.
- The counter is wide enough to hold TIMEOUT without wrap: clog2(TIMEOUT+1) bits.

## Test plan
- Single job, req0 A=143 B=78, real datapath/controlpath:
  - `gnt`=0001 in cycle 1.
  - `gcd_data_in` = 143 then 78, with `gcd_start` high for exactly those 2 cycles.
  - `rsp_gcd`=13, `rsp_id`=0, `rsp_err`=0.
- All four `req` held high, `rsp_ready`=1:
  - Grant order is 0,1,2,3,0,1.
  - Results match a reference gcd, e.g. (48,18)->6, (17,5)->1, (100,75)->25, (65535,1)->1.
- Zero operands:
  - (0,25) on req2 -> `rsp_gcd`=25, `rsp_id`=2 in cycle 1, `gcd_start` never asserted.
  - (40,0) -> 40; (0,0) -> 0.
- Backpressure: `rsp_ready` low for 5 cycles in RESP.
  - `rsp_valid`, `rsp_id`, `rsp_gcd` stay stable.
  - `busy`=1; no `gnt` even with `req` pending.
  - Response is consumed on the first `rsp_ready`; the next grant follows 2 edges later.
- Timeout, with TIMEOUT=20 and a stub core that never asserts done:
  - `rsp_err`=1, `rsp_gcd`=0 in the cycle after the 20th RUN cycle.
  - The following job with a working core completes normally.
- Reset, `rst` pulsed during RUN of (143,78) on req1:
  - All outputs are 0 on the next cycle; no response is ever issued for req1.
  - The next arbitration with `req`=1111 grants requester 0.
